sha256_block_sequencer: RTL

Controller that sequences the single-block SHA-256 compression core (RTL_crypto_hashblocks_sha256) across multi-block messages. It accepts padded 512-bit blocks on a valid/ready stream tagged first/last, and issues one core start per block. It selects IV or the chained digest for each block, captures the core result, and presents the final 256-bit digest on a valid/ready output. A watchdog flags a core that never responds.

---
 rtl/sha256_block_sequencer.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/sha256_block_sequencer.sv
// sha256_block_sequencer
//
// Drives a single-block SHA-256 compression core across multi-block messages.
// Padded 512-bit blocks arrive on a valid/ready stream and are tagged first/last.
// For each block the sequencer selects the chaining value (the IV or the
// previous core result), pulses core_start_out for one cycle, and waits for the
// core's result. After the last block it presents the digest on a valid/ready
// output. A watchdog moves to a sticky error state if the core stays silent.
//
// Ports:
//   CLK, RST            clock; synchronous active-high reset
//   blk_valid_in/blk_ready_out, blk_data_in, blk_first_in, blk_last_in
//                       block input stream
//   core_start_out, core_message_out, core_digest_out
//                       request to the compression core
//   core_digest_in, core_valid_in
//                       core result (feed-forward add already applied)
//   hash_valid_out/hash_ready_in, hash_digest_out
//                       final digest stream
//   busy_out            message in flight, or the sequencer is not idle
//   blk_count_out       blocks completed in the current message (saturating)
//   timeout_err_out     sticky watchdog error; cleared only by RST
module sha256_block_sequencer #(
    parameter logic [255:0] IV = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19,
    parameter int CNT_W = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               blk_valid_in,
    output logic               blk_ready_out,
    input  logic [511:0]       blk_data_in,
    input  logic               blk_first_in,
    input  logic               blk_last_in,
    output logic               core_start_out,
    output logic [511:0]       core_message_out,
    output logic [255:0]       core_digest_out,
    input  logic [255:0]       core_digest_in,
    input  logic               core_valid_in,
    output logic               hash_valid_out,
    input  logic               hash_ready_in,
    output logic [255:0]       hash_digest_out,
    output logic               busy_out,
    output logic [CNT_W-1:0]   blk_count_out,
    output logic               timeout_err_out
);

    localparam int WD_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, START, WAIT, DONE, ERR} state_t;

    state_t            state_reg;
    logic              msg_open_reg;
    logic              last_reg;
    logic              valid_q_reg;
    logic [255:0]      chain_reg;
    logic [WD_W-1:0]   wd_reg;

    // A core result is taken only on a rising edge of core_valid_in, so a
    // valid held high for several cycles is counted once. A valid that was
    // already high before WAIT was entered therefore cannot be mistaken for
    // the result of the new block.
    logic core_take;
    assign core_take = core_valid_in && !valid_q_reg;

    // The WAIT edge on which the counter would reach TIMEOUT_CYCLES is the
    // edge that enters ERR. This places the error flag exactly
    // TIMEOUT_CYCLES cycles after START is left.
    logic wd_expire;
    assign wd_expire = (TIMEOUT_CYCLES != 0) && (wd_reg == WD_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg        <= IDLE;
            msg_open_reg     <= 1'b0;
            last_reg         <= 1'b0;
            valid_q_reg      <= 1'b0;
            chain_reg        <= IV;
            wd_reg           <= '0;
            blk_ready_out    <= 1'b1;
            core_start_out   <= 1'b0;
            core_message_out <= '0;
            core_digest_out  <= '0;
            hash_valid_out   <= 1'b0;
            hash_digest_out  <= '0;
            busy_out         <= 1'b0;
            blk_count_out    <= '0;
            timeout_err_out  <= 1'b0;
        end else begin
            valid_q_reg    <= core_valid_in;
            core_start_out <= 1'b0;

            case (state_reg)
                IDLE: begin
                    // blk_ready_out is always high while in IDLE.
                    if (blk_valid_in) begin
                        core_message_out <= blk_data_in;
                        last_reg         <= blk_last_in;
                        msg_open_reg     <= 1'b1;
                        busy_out         <= 1'b1;
                        blk_ready_out    <= 1'b0;
                        core_start_out   <= 1'b1;
                        state_reg        <= START;
                        // A first block, or any block with no message open,
                        // starts a new chain. A stale chain is abandoned.
                        if (blk_first_in || !msg_open_reg) begin
                            core_digest_out <= IV;
                            blk_count_out   <= '0;
                        end else begin
                            core_digest_out <= chain_reg;
                        end
                    end
                end

                START: begin
                    wd_reg    <= '0;
                    state_reg <= WAIT;
                end

                WAIT: begin
                    if (core_take) begin
                        chain_reg <= core_digest_in;
                        if (blk_count_out != '1) begin
                            blk_count_out <= blk_count_out + 1'b1;
                        end
                        if (last_reg) begin
                            hash_digest_out <= core_digest_in;
                            hash_valid_out  <= 1'b1;
                            state_reg       <= DONE;
                        end else begin
                            blk_ready_out <= 1'b1;
                            state_reg     <= IDLE;
                        end
                    end else begin
                        wd_reg <= wd_reg + 1'b1;
                        if (wd_expire) begin
                            timeout_err_out <= 1'b1;
                            msg_open_reg    <= 1'b0;
                            state_reg       <= ERR;
                        end
                    end
                end

                DONE: begin
                    if (hash_ready_in) begin
                        hash_valid_out <= 1'b0;
                        msg_open_reg   <= 1'b0;
                        busy_out       <= 1'b0;
                        blk_ready_out  <= 1'b1;
                        state_reg      <= IDLE;
                    end
                end

                ERR: begin
                    // Only RST leaves this state.
                end

                default: begin
                    state_reg <= ERR;
                end
            endcase
        end
    end

endmodule
